// File: rtl/unified_mem_arbiter.sv
// Arbiter that lets instruction fetch and data access share one single-ported memory.
// Define ARB_RR_EN to use round-robin arbitration on ties. Without it, D always beats I.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_F,
    output logic              stall_M,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               drop;
    logic               at_limit;
    logic               finish;
    logic               i_ok;
    logic               pick_i;

    // A transaction ends on a response or when the wait budget runs out. A response wins a tie.
    assign at_limit = (cnt == CNT_W'(TIMEOUT));
    assign finish   = mem_rvalid || at_limit;
    assign i_ok     = if_req && !if_kill;

`ifdef ARB_RR_EN
    logic last_i;
    assign pick_i = i_ok && (!dm_req || !last_i);
`else
    assign pick_i = i_ok && !dm_req;
`endif

    assign if_done     = !rst && (state == WAIT_I) && finish && !drop && !if_kill;
    assign dm_done     = !rst && (state == WAIT_D) && finish;
    assign err_timeout = !rst && (state != IDLE) && at_limit && !mem_rvalid;
    assign if_rdata    = mem_rdata;
    assign dm_rdata    = mem_rdata;
    assign stall_F     = if_req && !if_done;
    assign stall_M     = dm_req && !dm_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            drop      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef ARB_RR_EN
            last_i    <= 1'b0;
`endif
        end else begin
            mem_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_i) begin
                        state     <= WAIT_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        cnt       <= '0;
`ifdef ARB_RR_EN
                        last_i    <= 1'b1;
`endif
                    end else if (dm_req) begin
                        state     <= WAIT_D;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        cnt       <= '0;
`ifdef ARB_RR_EN
                        last_i    <= 1'b0;
`endif
                    end
                end
                WAIT_I: begin
                    // A kill seen in the same cycle as the response is handled combinationally on if_done.
                    if (finish) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (if_kill) drop <= 1'b1;
                    end
                end
                WAIT_D: begin
                    if (finish) state <= IDLE;
                    else        cnt   <= cnt + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
